bcd_seg_scanner: RTL and testbench



---
 rtl/seg7_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/bcd_seg_scanner.sv | 118 +++++++++++
 tb/tb_bcd_seg_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: active-high segment
// patterns ({g,f,e,d,c,b,a}, a = bit 0), bus widths and index sizing.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Bits needed to index n digits; never less than one so N_DIGITS=1 still has a vector.
  function automatic int unsigned idx_width(input int unsigned n);
    idx_width = 1;
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) < n) idx_width = w + 1;
    end
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes A-F decode to blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment driver with shadow/display double buffer.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_seg_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      LOAD,
  input  logic [BCD_W*N_DIGITS-1:0] BCD_IN,
  output logic [SEG_W-1:0]          SEG,
  output logic [N_DIGITS-1:0]       DIG,
  output logic                      FRAME_DONE
);

  localparam int unsigned DATA_W = BCD_W * N_DIGITS;
  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = idx_width(N_DIGITS);

  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [SEG_W-1:0]    SEG_OFF  = ACTIVE_LOW ? '1 : '0;
  localparam logic [N_DIGITS-1:0] DIG_OFF  = ACTIVE_LOW ? '1 : '0;

  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   shadow;
  logic [DATA_W-1:0]   display;
  logic                term_c;
  logic                frame_end_c;
  logic [BCD_W-1:0]    nib_c;
  logic                blank_c;
  logic [N_DIGITS-1:0] dig_c;
  logic [N_DIGITS-1:0] lz_mask_c;
  logic [SEG_W-1:0]    dec_c;
  logic [SEG_W-1:0]    seg_c;

  assign term_c      = (presc == PRE_LAST);
  assign frame_end_c = term_c && (idx == IDX_LAST);

  // Slot prescaler and digit index.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      presc <= '0;
      idx   <= '0;
    end else if (term_c) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Display only takes the shadow at a frame boundary, so a frame never tears.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      shadow  <= '0;
      display <= '0;
    end else begin
      if (LOAD)        shadow  <= BCD_IN;
      if (frame_end_c) display <= shadow;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic run_c;

  // A digit above 0 blanks while it and everything above it is zero.
  always_comb begin
    lz_mask_c = '0;
    run_c     = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      run_c        = run_c && (display[i*BCD_W +: BCD_W] == 4'd0);
      lz_mask_c[i] = run_c;
    end
  end
`else
  assign lz_mask_c = '0;
`endif

  // Current digit select; enables are held off during slot cycle 0 to hide ghosting.
  always_comb begin
    nib_c   = '0;
    blank_c = 1'b0;
    dig_c   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_c    = display[i*BCD_W +: BCD_W];
        blank_c  = lz_mask_c[i];
        dig_c[i] = (presc != '0);
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (nib_c),
    .seg_c (dec_c)
  );

  assign seg_c = blank_c ? SEG_BLANK : dec_c;

  // Output register; polarity applied here only.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      SEG        <= SEG_OFF;
      DIG        <= DIG_OFF;
      FRAME_DONE <= 1'b0;
    end else begin
      SEG        <= ACTIVE_LOW ? ~seg_c : seg_c;
      DIG        <= ACTIVE_LOW ? ~dig_c : dig_c;
      FRAME_DONE <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner: one active-high and one active-low instance
// share stimulus; expectations come from cycle arithmetic plus a shadow/display model.
module tb_bcd_seg_scanner;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int F  = N * SD;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        LOAD;
  logic [15:0] BCD_IN;
  logic [6:0]  seg_h, seg_l;
  logic [3:0]  dig_h, dig_l;
  logic        fd_h, fd_l;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  logic [15:0] shadow_m = '0;
  logic [15:0] disp_m   = '0;
  exp_t        sb[$];

  bcd_seg_scanner #(.N_DIGITS(N), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) u_dut (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .BCD_IN(BCD_IN),
    .SEG(seg_h), .DIG(dig_h), .FRAME_DONE(fd_h)
  );

  bcd_seg_scanner #(.N_DIGITS(N), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) u_dut_al (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .BCD_IN(BCD_IN),
    .SEG(seg_l), .DIG(dig_l), .FRAME_DONE(fd_l)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  function automatic logic [6:0] ref_seg7(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] disp, input int ix);
    logic [6:0] s;
    s = ref_seg7(disp[ix*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (ix > 0) begin
      logic allz;
      allz = 1'b1;
      for (int j = ix; j < N; j++) if (disp[j*4 +: 4] != 4'd0) allz = 1'b0;
      if (allz) s = 7'h00;
    end
`endif
    return s;
  endfunction

  task automatic model_reset();
    edge_cnt = 0;
    shadow_m = '0;
    disp_m   = '0;
  endtask

  // Called at a negedge: drive inputs, queue the expectation for the coming edge, compare.
  task automatic tick(input logic ld, input logic [15:0] val);
    exp_t       e;
    int         c;
    int         ix;
    logic [6:0] seg_inv;
    logic [3:0] dig_inv;
    LOAD   = ld;
    BCD_IN = val;
    c      = edge_cnt;
    ix     = (c / SD) % N;
    e.dig  = (c % SD == 0) ? 4'h0 : 4'(1 << ix);
    e.seg  = model_seg(disp_m, ix);
    e.fd   = (c % F == F - 1);
    sb.push_back(e);
    if (c % F == F - 1) disp_m = shadow_m;
    if (ld) shadow_m = val;
    edge_cnt++;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e       = sb.pop_front();
      seg_inv = ~e.seg;
      dig_inv = ~e.dig;
      check_eq("seg_hi", 32'(seg_h), 32'(e.seg));
      check_eq("dig_hi", 32'(dig_h), 32'(e.dig));
      check_eq("fd_hi",  32'(fd_h),  32'(e.fd));
      check_eq("seg_lo", 32'(seg_l), 32'(seg_inv));
      check_eq("dig_lo", 32'(dig_l), 32'(dig_inv));
      check_eq("fd_lo",  32'(fd_l),  32'(e.fd));
    end
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000);
  endtask

  task automatic to_phase(input int p);
    while (edge_cnt % F != p) tick(1'b0, 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_seg_hi"}, 32'(seg_h), 32'h00);
    check_eq({tag, "_dig_hi"}, 32'(dig_h), 32'h0);
    check_eq({tag, "_fd_hi"},  32'(fd_h),  32'h0);
    check_eq({tag, "_seg_lo"}, 32'(seg_l), 32'h7F);
    check_eq({tag, "_dig_lo"}, 32'(dig_l), 32'hF);
    check_eq({tag, "_fd_lo"},  32'(fd_l),  32'h0);
  endtask

  initial begin
    CLR    = 1'b0;
    LOAD   = 1'b0;
    BCD_IN = '0;
    #1 CLR = 1'b1;
    #2;
    check_reset_outputs("rst");

    @(negedge CLK);
    CLR = 1'b0;
    model_reset();
    run(2 * F);

    // Decode of 9876, shown one frame after capture.
    tick(1'b1, 16'h9876);
    run(3 * F);

    // Mid-frame loads: last one wins, visible only after the next boundary.
    to_phase(3);
    tick(1'b1, 16'h5555);
    to_phase(9);
    tick(1'b1, 16'h1234);
    run(2 * F);

    // Load on the boundary cycle: display takes the old shadow first.
    to_phase(F - 1);
    tick(1'b1, 16'h4321);
    run(2 * F);

    // Invalid code blanks; leading-zero cases; digit 8 for polarity.
    tick(1'b1, 16'h00F5);
    run(2 * F);
    tick(1'b1, 16'h0005);
    run(2 * F);
    tick(1'b1, 16'h0000);
    run(2 * F);
    tick(1'b1, 16'h0808);
    run(2 * F);

    // Asynchronous reset in slot 2, checked before any clock edge.
    to_phase(9);
    CLR = 1'b1;
    #1;
    check_reset_outputs("async");
    @(negedge CLK);
    CLR = 1'b0;
    model_reset();
    run(2 * F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
